// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate-format
// encodings, and the control bundle produced by the decoder.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    alu_op_e   alu_op;
    imm_type_e imm_type;
    logic      alu_src;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      illegal;
    logic      use_rs1;
    logic      use_rs2;
  } ctrl_t;

  // funct7[5] selects SUB only for register-register ops; for shifts it selects SRA.
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic f7b5,
                                             input logic is_op);
    case (funct3)
      3'b000:  return (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: selects and sign-extends the
// immediate field of an instruction according to its format.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{21{instr[31]}}, instr[30:20]};
      IMM_S: imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction into a registered bundle,
// drives register-file read addresses, and stalls RAW hazards via a pending-write scoreboard.
module decode_stage
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output alu_op_e         out_alu_op,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that
  // side; valid never depends on ready, and a held bundle stays frozen until issued.
  logic [6:0]      opcode;
  logic [4:0]      rs1_f, rs2_f, rd_f;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm;
  logic            hazard, accept, issue;
  logic [31:0]     pending, pending_next;

  assign opcode = in_instr[6:0];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign rd_f   = in_instr[11:7];

  always_comb begin
    ctrl          = '0;
    ctrl.alu_op   = ALU_ADD;
    ctrl.imm_type = IMM_NONE;
    case (opcode)
      OPC_LUI: begin
        ctrl.imm_type = IMM_U; ctrl.alu_op = ALU_PASS_B;
        ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm_type = IMM_U; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm_type = IMM_J; ctrl.alu_src = 1'b1;
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1;
      end
      OPC_JALR: begin
        ctrl.imm_type = IMM_I; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.jump = 1'b1; ctrl.use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.imm_type = IMM_B; ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1;
        ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.imm_type = IMM_I; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl.imm_type = IMM_S; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.imm_type = IMM_I; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.use_rs1 = 1'b1;
        ctrl.alu_op = alu_from_funct(in_instr[14:12], in_instr[30], 1'b0);
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1; ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
        ctrl.alu_op = alu_from_funct(in_instr[14:12], in_instr[30], 1'b1);
      end
      OPC_FENCE, OPC_SYSTEM: begin
        ctrl.illegal = 1'b0;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .instr    (in_instr),
    .imm_type (ctrl.imm_type),
    .imm      (imm)
  );

  // Registered pending bits only: a writeback clear is seen one cycle later,
  // so the register file has committed the value before the consumer reads it.
  assign hazard = (ctrl.use_rs1 && (rs1_f != 5'd0) && pending[rs1_f]) ||
                  (ctrl.use_rs2 && (rs2_f != 5'd0) && pending[rs2_f]);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign issue    = out_valid && out_ready;

  assign rf_rs1 = accept ? rs1_f : out_rs1;
  assign rf_rs2 = accept ? rs2_f : out_rs2;

  always_comb begin
    pending_next = pending;
    if (wb_valid)
      pending_next[wb_rd] = 1'b0;
    if (flush && out_valid && out_reg_write && (out_rd != 5'd0))
      pending_next[out_rd] = 1'b0;
    if (accept && ctrl.reg_write && (rd_f != 5'd0))
      pending_next[rd_f] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_imm       <= '0;
      out_alu_op    <= ALU_ADD;
      out_alu_src   <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_branch    <= 1'b0;
      out_jump      <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1       <= rs1_f;
      out_rs2       <= rs2_f;
      out_rd        <= rd_f;
      out_imm       <= imm;
      out_alu_op    <= ctrl.alu_op;
      out_alu_src   <= ctrl.alu_src;
      out_reg_write <= ctrl.reg_write;
      out_mem_read  <= ctrl.mem_read;
      out_mem_write <= ctrl.mem_write;
      out_branch    <= ctrl.branch;
      out_jump      <= ctrl.jump;
      out_illegal   <= ctrl.illegal;
    end else if (issue) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction-decode pipeline stage, sitting directly upstream of the register file and feeding the execute stage. Accepts fetched instructions over a valid/ready handshake and extracts register indices, immediate and control signals into an output register. Drives the register file's read addresses so its registered read data lines up with the decoded bundle. A 32-entry pending-write scoreboard stalls read-after-write hazards until writeback retires the producer.

## Interface
- XLEN, 32, datapath width; only 32 supported.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  kill held instruction (branch redirect).
- rf_rs1, rf_rs2  out  5  register-file read addresses.
- wb_valid  in  1  writeback retiring a register write.
- wb_rd  in  5  register written by that retirement.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes bundle.
- out_pc  out  XLEN  PC of bundle.
- out_rs1, out_rs2, out_rd  out  5  register fields.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_op  out  4  ALU operation, package enum.
- out_alu_src  out  1  0 = rs2, 1 = immediate.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump  out  1  control.
- out_illegal  out  1  undecodable instruction.

## Operation
- accept = in_valid && in_ready; issue = out_valid && out_ready.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- hazard: instruction uses rs1 (or rs2) with nonzero index whose pending bit is set; uses derived from opcode (U/J-type use none; I-type/load/JALR rs1 only; R/S/B both).
- Scoreboard: pending[31:0], registered. On accept with reg_write && rd != 0: set pending[rd]. On wb_valid: clear pending[wb_rd]. Same register set and cleared in one cycle: set wins. pending[0] always 0.
- Hazard check uses registered pending only; a clear becomes visible next cycle (guarantees regfile write precedes the read).
- rf_rs1/rf_rs2 = in_instr fields when accept, else held out_rs1/out_rs2, so regfile data stays valid during backpressure.
- Immediates: I, S, B, U, J per RV32I, sign bit instr[31]; B/J bit 0 = 0.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (NOP), SYSTEM (NOP). Other opcode or instr[1:0] != 11: out_illegal = 1, all write/mem controls 0.
- flush: out_valid cleared next edge; if held instruction set a pending bit, that bit is cleared; no capture that cycle.

## Timing
- Reset: out_valid 0, pending all 0, every other output register 0 (out_alu_op = ADD encoding 0).
- Latency: accept at edge N → out_valid high after edge N; regfile data valid same cycle.
- Throughput one instruction per cycle with no hazards and out_ready high.
- out_* stable while out_valid && !out_ready.
- Hazard stall lasts until the cycle after wb_valid for the blocking register.
- Reset mid-stall or mid-handshake: everything to reset values immediately.

## Structure
- Package rv32i_pkg: opcode constants, alu_op enum, immediate-type enum, XLEN.
- Sub-module imm_gen (combinational immediate generator, instr + type → imm); scoreboard and decode control inline.

## Test plan
- Reset asserted mid-stream → out_valid 0, pending 0, in_ready 1 after release with in_valid high.
- ADDI x5,x0,-1 (0xFFF00293) → out_rd 5, out_imm 0xFFFFFFFF, alu_src 1, reg_write 1, pending[5] set.
- ADDI x5 then ADD x6,x5,x5 → in_ready low until cycle after wb_valid/wb_rd=5; then accepted.
- out_ready low 3 cycles with bundle rs1=7 → out_* and rf_rs1=7 held constant.
- BEQ with offset −8 → out_imm 0xFFFFFFF8, branch 1, reg_write 0; flush next cycle → out_valid 0.
- ADDI x0,x0,0 → pending stays 0; opcode 0x7F → out_illegal 1, reg_write 0.
